// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue controller: ALU control codes, ALUOp and funct
// values, FSM states and the decoder output bundle.
package alu_pkg;

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_LUI  = 4'b0011;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_SRA  = 4'b1000;
    localparam logic [3:0] CTRL_SRAV = 4'b1001;
    localparam logic [3:0] CTRL_BAD  = 4'b1111;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_BEQ   = 3'b001,
        OP_RTYPE = 3'b010,
        OP_LUI   = 3'b011,
        OP_ORI   = 3'b100,
        OP_SLTI  = 3'b101,
        OP_BNE   = 3'b110,
        OP_BAD   = 3'b111
    } aluop_e;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SRAV = 6'h07;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       is_beq;
        logic       is_bne;
        logic       err;
    } dec_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALUOp/funct decoder producing the ALU control code, the branch kind
// and an error flag for unsupported encodings.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [2:0] aluop,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        // NOTE: defaults first so every path assigns every field and no latch is inferred.
        dec = '{ctrl: CTRL_BAD, is_beq: 1'b0, is_bne: 1'b0, err: 1'b0};
        case (aluop)
            OP_ADD:  dec.ctrl = CTRL_ADD;
            OP_BEQ: begin
                dec.ctrl   = CTRL_SUB;
                dec.is_beq = 1'b1;
            end
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  dec.ctrl = CTRL_ADD;
                    FN_SUB:  dec.ctrl = CTRL_SUB;
                    FN_AND:  dec.ctrl = CTRL_AND;
                    FN_OR:   dec.ctrl = CTRL_OR;
                    FN_SLT:  dec.ctrl = CTRL_SLT;
                    FN_SRA:  dec.ctrl = CTRL_SRA;
                    FN_SRAV: dec.ctrl = CTRL_SRAV;
                    default: dec.err  = 1'b1;
                endcase
            end
            OP_LUI:  dec.ctrl = CTRL_LUI;
            OP_ORI:  dec.ctrl = CTRL_OR;
            OP_SLTI: dec.ctrl = CTRL_SLT;
            OP_BNE: begin
                dec.ctrl   = CTRL_SUB;
                dec.is_bne = 1'b1;
            end
            default: dec.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one ALU operation per request handshake, captures the combinational ALU
// result a cycle later and holds the response until the consumer takes it.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_aluop_i,
    input  logic [5:0]       req_funct_i,
    input  logic [DW-1:0]    req_src1_i,
    input  logic [DW-1:0]    req_src2_i,
    input  logic [4:0]       req_shamt_i,
    output logic [DW-1:0]    alu_src1_o,
    output logic [DW-1:0]    alu_src2_o,
    output logic [4:0]       alu_shamt_o,
    output logic [3:0]       alu_ctrl_o,
    input  logic [DW-1:0]    alu_result_i,
    input  logic             alu_zero_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [DW-1:0]    rsp_result_o,
    output logic             rsp_zero_o,
    output logic             rsp_taken_o,
    output logic             rsp_err_o,
    output logic [CNT_W-1:0] issued_cnt_o
);

    state_e state;
    dec_t   dec;
    logic   is_beq_q;
    logic   is_bne_q;
    logic   err_q;

    alu_ctrl_dec u_dec (
        .aluop (req_aluop_i),
        .funct (req_funct_i),
        .dec   (dec)
    );

    // NOTE: every register is a plain flop (no arrays), so all of them are reset and
    // all state updates use non-blocking assignments to avoid ordering races.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state        <= ST_IDLE;
            req_ready_o  <= 1'b1;
            alu_src1_o   <= '0;
            alu_src2_o   <= '0;
            alu_shamt_o  <= '0;
            alu_ctrl_o   <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_result_o <= '0;
            rsp_zero_o   <= 1'b0;
            rsp_taken_o  <= 1'b0;
            rsp_err_o    <= 1'b0;
            issued_cnt_o <= '0;
            is_beq_q     <= 1'b0;
            is_bne_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        alu_src1_o   <= req_src1_i;
                        alu_src2_o   <= req_src2_i;
                        alu_shamt_o  <= req_shamt_i;
                        alu_ctrl_o   <= dec.ctrl;
                        is_beq_q     <= dec.is_beq;
                        is_bne_q     <= dec.is_bne;
                        err_q        <= dec.err;
                        // Status flags of the previous response live until the next issue.
                        rsp_zero_o   <= 1'b0;
                        rsp_taken_o  <= 1'b0;
                        rsp_err_o    <= 1'b0;
                        issued_cnt_o <= issued_cnt_o + CNT_W'(1);
                        req_ready_o  <= 1'b0;
                        state        <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result_o <= alu_result_i;
                    rsp_zero_o   <= alu_zero_i;
                    rsp_taken_o  <= !err_q && ((is_beq_q && alu_zero_i) ||
                                               (is_bne_q && !alu_zero_i));
                    rsp_err_o    <= err_q;
                    rsp_valid_o  <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_o <= 1'b0;
                    req_ready_o <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl driving a behavioural ALU; counter width is
// reduced to 2 bits so the wrap is reached quickly.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_aluop_i;
    logic [5:0]  req_funct_i;
    logic [31:0] req_src1_i;
    logic [31:0] req_src2_i;
    logic [4:0]  req_shamt_i;
    logic [31:0] alu_src1_o;
    logic [31:0] alu_src2_o;
    logic [4:0]  alu_shamt_o;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] alu_result_i;
    logic        alu_zero_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic        rsp_zero_o;
    logic        rsp_taken_o;
    logic        rsp_err_o;
    logic [1:0]  issued_cnt_o;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        taken;
        logic        err;
    } exp_t;

    exp_t       sb[$];
    int         vectors     = 0;
    int         miscompares = 0;
    logic [1:0] exp_cnt     = '0;

    alu_issue_ctrl #(.DW(32), .CNT_W(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_aluop_i  (req_aluop_i),
        .req_funct_i  (req_funct_i),
        .req_src1_i   (req_src1_i),
        .req_src2_i   (req_src2_i),
        .req_shamt_i  (req_shamt_i),
        .alu_src1_o   (alu_src1_o),
        .alu_src2_o   (alu_src2_o),
        .alu_shamt_o  (alu_shamt_o),
        .alu_ctrl_o   (alu_ctrl_o),
        .alu_result_i (alu_result_i),
        .alu_zero_i   (alu_zero_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_result_o (rsp_result_o),
        .rsp_zero_o   (rsp_zero_o),
        .rsp_taken_o  (rsp_taken_o),
        .rsp_err_o    (rsp_err_o),
        .issued_cnt_o (issued_cnt_o)
    );

    // Combinational ALU on the far side of the interface.
    always_comb begin
        alu_result_i = '0;
        case (alu_ctrl_o)
            4'b0000: alu_result_i = alu_src1_o & alu_src2_o;
            4'b0001: alu_result_i = alu_src1_o | alu_src2_o;
            4'b0010: alu_result_i = alu_src1_o + alu_src2_o;
            4'b0011: alu_result_i = {alu_src2_o[15:0], 16'h0000};
            4'b0110: alu_result_i = alu_src1_o - alu_src2_o;
            4'b0111: alu_result_i = {31'b0, $signed(alu_src1_o) < $signed(alu_src2_o)};
            4'b1000: alu_result_i = $signed(alu_src2_o) >>> alu_shamt_o;
            4'b1001: alu_result_i = $signed(alu_src2_o) >>> alu_src1_o[4:0];
            default: alu_result_i = '0;
        endcase
    end
    assign alu_zero_i = (alu_result_i == 32'h0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_req(input string name, input logic [2:0] op, input logic [5:0] fn,
                            input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        int budget = 0;
        @(negedge clk);
        req_aluop_i = op;
        req_funct_i = fn;
        req_src1_i  = a;
        req_src2_i  = b;
        req_shamt_i = sh;
        req_valid_i = 1'b1;
        while (!req_ready_o && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        vectors++;
        if (req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s req_ready timeout: got %b want 1", name, req_ready_o);
        end
        @(posedge clk);
        exp_cnt = exp_cnt + 2'd1;
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    task automatic expect_rsp(input string name);
        int   budget = 0;
        exp_t e;
        while (!rsp_valid_o && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        vectors++;
        if (rsp_valid_o !== 1'b1 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s rsp_valid timeout: got %b want 1 (queue %0d)", name, rsp_valid_o, sb.size());
            return;
        end
        e = sb.pop_front();
        vectors += 5;
        if (rsp_result_o !== e.result) begin
            miscompares++;
            $display("FAIL %s result: got %h want %h", name, rsp_result_o, e.result);
        end
        if (rsp_zero_o !== e.zero) begin
            miscompares++;
            $display("FAIL %s zero: got %b want %b", name, rsp_zero_o, e.zero);
        end
        if (rsp_taken_o !== e.taken) begin
            miscompares++;
            $display("FAIL %s taken: got %b want %b", name, rsp_taken_o, e.taken);
        end
        if (rsp_err_o !== e.err) begin
            miscompares++;
            $display("FAIL %s err: got %b want %b", name, rsp_err_o, e.err);
        end
        if (issued_cnt_o !== exp_cnt) begin
            miscompares++;
            $display("FAIL %s issued_cnt: got %0d want %0d", name, issued_cnt_o, exp_cnt);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready_i = 1'b0;
        vectors += 2;
        if (rsp_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s rsp_valid after pop: got %b want 0", name, rsp_valid_o);
        end
        if (req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s req_ready after pop: got %b want 1", name, req_ready_o);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                          input logic [3:0] exp_ctrl, input logic [31:0] exp_result,
                          input logic exp_zero, input logic exp_taken, input logic exp_err);
        sb.push_back('{result: exp_result, zero: exp_zero, taken: exp_taken, err: exp_err});
        send_req(name, op, fn, a, b, sh);
        vectors += 3;
        if (alu_ctrl_o !== exp_ctrl) begin
            miscompares++;
            $display("FAIL %s ctrl: got %b want %b", name, alu_ctrl_o, exp_ctrl);
        end
        if (rsp_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s early rsp_valid: got %b want 0", name, rsp_valid_o);
        end
        if (req_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s req_ready in EXEC: got %b want 0", name, req_ready_o);
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (rsp_valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s latency: rsp_valid got %b want 1 after edge k+2", name, rsp_valid_o);
        end
        expect_rsp(name);
    endtask

    task automatic check_zeroed(input string name);
        vectors += 4;
        if ({alu_src1_o, alu_src2_o, alu_shamt_o, alu_ctrl_o} !== '0) begin
            miscompares++;
            $display("FAIL %s alu outputs: got %h/%h/%h/%h want 0", name, alu_src1_o, alu_src2_o, alu_shamt_o, alu_ctrl_o);
        end
        if ({rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_taken_o, rsp_err_o} !== '0) begin
            miscompares++;
            $display("FAIL %s rsp outputs: got v%b r%h z%b t%b e%b want 0", name, rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_taken_o, rsp_err_o);
        end
        if (issued_cnt_o !== 2'd0) begin
            miscompares++;
            $display("FAIL %s issued_cnt: got %0d want 0", name, issued_cnt_o);
        end
        if (req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s req_ready: got %b want 1", name, req_ready_o);
        end
    endtask

    task automatic test_reset();
        rst_i       = 1'b0;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        req_aluop_i = '0;
        req_funct_i = '0;
        req_src1_i  = '0;
        req_src2_i  = '0;
        req_shamt_i = '0;
        repeat (3) @(negedge clk);
        check_zeroed("reset");
        rst_i   = 1'b1;
        exp_cnt = '0;
    endtask

    task automatic test_alu_ops();
        run_op("rtype_add", 3'b010, 6'h20, 32'd5, 32'd7, 5'd0, 4'b0010, 32'd12, 1'b0, 1'b0, 1'b0);
        run_op("rtype_sub", 3'b010, 6'h22, 32'd10, 32'd3, 5'd0, 4'b0110, 32'd7, 1'b0, 1'b0, 1'b0);
        run_op("rtype_and", 3'b010, 6'h24, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 4'b0000, 32'h0F000F00, 1'b0, 1'b0, 1'b0);
        run_op("rtype_or", 3'b010, 6'h25, 32'h1, 32'h2, 5'd0, 4'b0001, 32'h3, 1'b0, 1'b0, 1'b0);
        run_op("rtype_slt", 3'b010, 6'h2A, 32'd5, 32'd3, 5'd0, 4'b0111, 32'd0, 1'b1, 1'b0, 1'b0);
        run_op("add_wrap", 3'b000, 6'h00, 32'hFFFFFFFF, 32'd1, 5'd0, 4'b0010, 32'd0, 1'b1, 1'b0, 1'b0);
        run_op("slti_neg", 3'b101, 6'h00, 32'hFFFFFFFF, 32'd1, 5'd0, 4'b0111, 32'd1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_branch();
        run_op("beq_equal", 3'b001, 6'h00, 32'h1234, 32'h1234, 5'd0, 4'b0110, 32'd0, 1'b1, 1'b1, 1'b0);
        run_op("bne_equal", 3'b110, 6'h00, 32'h1234, 32'h1234, 5'd0, 4'b0110, 32'd0, 1'b1, 1'b0, 1'b0);
        run_op("beq_diff", 3'b001, 6'h00, 32'd1, 32'd2, 5'd0, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        run_op("bne_diff", 3'b110, 6'h00, 32'd1, 32'd2, 5'd0, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_shift_lui();
        run_op("sra", 3'b010, 6'h03, 32'h0, 32'h80000000, 5'd4, 4'b1000, 32'hF8000000, 1'b0, 1'b0, 1'b0);
        run_op("srav", 3'b010, 6'h07, 32'd8, 32'hF0000000, 5'd0, 4'b1001, 32'hFFF00000, 1'b0, 1'b0, 1'b0);
        run_op("lui", 3'b011, 6'h00, 32'h0, 32'h0000ABCD, 5'd0, 4'b0011, 32'hABCD0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        sb.push_back('{result: 32'h00000FF0, zero: 1'b0, taken: 1'b0, err: 1'b0});
        send_req("bp", 3'b100, 6'h00, 32'h000000F0, 32'h00000F00, 5'd0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            req_valid_i = 1'b1;
            req_aluop_i = 3'b000;
            req_src1_i  = 32'hDEAD0000 + 32'(i);
            req_src2_i  = 32'h1;
            @(negedge clk);
            vectors += 5;
            if (rsp_valid_o !== 1'b1) begin
                miscompares++;
                $display("FAIL bp cycle %0d rsp_valid: got %b want 1", i, rsp_valid_o);
            end
            if (req_ready_o !== 1'b0) begin
                miscompares++;
                $display("FAIL bp cycle %0d req_ready: got %b want 0", i, req_ready_o);
            end
            if (rsp_result_o !== 32'h00000FF0) begin
                miscompares++;
                $display("FAIL bp cycle %0d result: got %h want 00000ff0", i, rsp_result_o);
            end
            if (issued_cnt_o !== exp_cnt) begin
                miscompares++;
                $display("FAIL bp cycle %0d issued_cnt: got %0d want %0d", i, issued_cnt_o, exp_cnt);
            end
            if (alu_src1_o !== 32'h000000F0) begin
                miscompares++;
                $display("FAIL bp cycle %0d alu_src1: got %h want 000000f0", i, alu_src1_o);
            end
        end
        req_valid_i = 1'b0;
        expect_rsp("bp");
    endtask

    task automatic test_error();
        run_op("bad_funct", 3'b010, 6'h3F, 32'd9, 32'd4, 5'd0, 4'b1111, 32'd0, 1'b1, 1'b0, 1'b1);
        run_op("err_clear", 3'b010, 6'h20, 32'd3, 32'd4, 5'd0, 4'b0010, 32'd7, 1'b0, 1'b0, 1'b0);
        run_op("bad_aluop", 3'b111, 6'h20, 32'h1234, 32'h1234, 5'd0, 4'b1111, 32'd0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid(input string name, input int extra_cycles);
        send_req(name, 3'b000, 6'h00, 32'd20, 32'd22, 5'd3);
        repeat (extra_cycles) @(negedge clk);
        if (extra_cycles > 0) begin
            vectors++;
            if (rsp_valid_o !== 1'b1) begin
                miscompares++;
                $display("FAIL %s pre-reset rsp_valid: got %b want 1", name, rsp_valid_o);
            end
        end
        rst_i = 1'b0;
        @(negedge clk);
        check_zeroed(name);
        rst_i   = 1'b1;
        exp_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL %s dropped rsp reappeared: got %b want 0", name, rsp_valid_o);
            end
        end
    endtask

    task automatic test_cnt_wrap();
        run_op("wrap1", 3'b000, 6'h00, 32'd1, 32'd1, 5'd0, 4'b0010, 32'd2, 1'b0, 1'b0, 1'b0);
        run_op("wrap2", 3'b000, 6'h00, 32'd2, 32'd2, 5'd0, 4'b0010, 32'd4, 1'b0, 1'b0, 1'b0);
        run_op("wrap3", 3'b000, 6'h00, 32'd3, 32'd3, 5'd0, 4'b0010, 32'd6, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (issued_cnt_o !== 2'd3) begin
            miscompares++;
            $display("FAIL wrap pre: issued_cnt got %0d want 3", issued_cnt_o);
        end
        run_op("wrap4", 3'b000, 6'h00, 32'd4, 32'd4, 5'd0, 4'b0010, 32'd8, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (issued_cnt_o !== 2'd0) begin
            miscompares++;
            $display("FAIL wrap: issued_cnt got %0d want 0", issued_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_branch();
        test_shift_lui();
        test_backpressure();
        test_error();
        test_reset_mid("reset_in_exec", 0);
        test_reset_mid("reset_in_resp", 1);
        test_cnt_wrap();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard leftover: got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
